vga_timing_gen: RTL

//  Produces 640x480@60 VGA raster timing: pixel coordinates x/y consumed by the game

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_timing_if.sv | 39 +++
 rtl/vga_sync_delay.sv | 39 +++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_timing_pkg: shared 640x480@60 raster constants, coordinate type, helper.
// Rev 1.0
//------------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_DISP = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_DISP = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_DISP + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISP + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // Idle value of the {video_on, hsync, vsync} bundle: blanked, syncs inactive.
  localparam logic [2:0] SYNC_IDLE = 3'b011;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_timing_if: raster enable, coordinates, ticks and pin-side sync bundle.
// Rev 1.0
//------------------------------------------------------------------------------
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic   en;
  logic   pix_tick;
  coord_t x;
  coord_t y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   line_tick;
  logic   frame_tick;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  modport master (
    input  en,
    output pix_tick, x, y, video_on, hsync, vsync, line_tick, frame_tick
`ifdef VGA_FRAME_CNT_EN
         , frame_cnt
`endif
  );

  modport slave (
    output en,
    input  pix_tick, x, y, video_on, hsync, vsync, line_tick, frame_tick
`ifdef VGA_FRAME_CNT_EN
         , frame_cnt
`endif
  );

endinterface
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_sync_delay: DEPTH-stage shift register, async reset to IDLE; DEPTH=0 is a wire.
// Rev 1.0
//------------------------------------------------------------------------------
module vga_sync_delay #(
  parameter int               DEPTH = 1,
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_timing_gen: pixel divider, h/v raster counters, ticks and delayed syncs.
// Rev 1.0 -- define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
//------------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_DISP   = vga_timing_pkg::H_DISP,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_DISP   = vga_timing_pkg::V_DISP,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int PIPE_DLY = 1
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);
  import vga_timing_pkg::*;

  localparam int H_LAST = H_DISP + H_FP + H_SYNC + H_BP - 1;
  localparam int V_LAST = V_DISP + V_FP + V_SYNC + V_BP - 1;
  localparam int HS_LO  = H_DISP + H_FP;
  localparam int HS_HI  = HS_LO + H_SYNC;
  localparam int VS_LO  = V_DISP + V_FP;
  localparam int VS_HI  = VS_LO + V_SYNC;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  coord_t           x;
  coord_t           y;
  logic             pix_tick;
  logic             x_last;
  logic             y_last;
  logic             line_tick;
  logic             frame_tick;
  logic [2:0]       sync_raw;
  logic [2:0]       sync_dly;

  // Gated by rst so the CLK_DIV=1 build also shows pix_tick=0 while held in reset.
  assign pix_tick   = vga.en && !rst && (div == DIV_LAST);
  assign x_last     = (x == COORD_W'(H_LAST));
  assign y_last     = (y == COORD_W'(V_LAST));
  assign line_tick  = pix_tick && x_last;
  assign frame_tick = line_tick && y_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (vga.en) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (pix_tick) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign sync_raw = {(x < COORD_W'(H_DISP)) && (y < COORD_W'(V_DISP)),
                     !in_window(x, COORD_W'(HS_LO), COORD_W'(HS_HI)),
                     !in_window(y, COORD_W'(VS_LO), COORD_W'(VS_HI))};

  vga_sync_delay #(
    .DEPTH (PIPE_DLY),
    .WIDTH (3),
    .IDLE  (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (sync_raw),
    .dout (sync_dly)
  );

  assign vga.pix_tick   = pix_tick;
  assign vga.x          = x;
  assign vga.y          = y;
  assign vga.line_tick  = line_tick;
  assign vga.frame_tick = frame_tick;
  assign vga.video_on   = sync_dly[2];
  assign vga.hsync      = sync_dly[1];
  assign vga.vsync      = sync_dly[0];

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign vga.frame_cnt = frame_cnt;
`endif

endmodule
`default_nettype wire
